veri_yolu_yanitlayici: RTL and testbench

// Bus-side responder for L1 cache block traffic (the "vy" interface driven by l1b/l1v denetleyici).

---
 rtl/veri_yolu_yanitlayici.sv | 176 +++++++++++++++++
 tb/tb_veri_yolu_yanitlayici.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/veri_yolu_yanitlayici.sv
// -----------------------------------------------------------------------------
// veri_yolu_yanitlayici
// Bus-side responder for L1 cache block traffic. It accepts one block read or
// block write from the L1 controller at a time. It then splits the block into
// BELLEK_VERI_BIT-wide beats on the main-memory port. Read beats are assembled
// into a full L1 block and returned on the vy data channel. Write blocks are
// drained beat by beat, and a write produces no vy response.
//
// Handshake rule, identical on every channel: a transfer happens on a rising
// clk edge where gecerli and hazir are both high. A source that raises gecerli
// keeps it and its payload unchanged until that edge.
//
// Ports
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   vy_istek_*               block request from L1 (adres, gecerli, hazir,
//                            yaz, veri)
//   vy_veri_*                read block back to L1 (veri, gecerli, hazir)
//   bellek_istek_*           beat request to memory (adres, gecerli, hazir,
//                            yaz, veri)
//   bellek_veri_*            read beat from memory (veri, gecerli, hazir)
//   durum_o                  current FSM state, for observation only
// -----------------------------------------------------------------------------
module veri_yolu_yanitlayici #(
    parameter int ADRES_BIT       = 32,
    parameter int L1_BLOK_BIT     = 128,
    parameter int BELLEK_VERI_BIT = 32
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [ADRES_BIT-1:0]       vy_istek_adres_i,
    input  logic                       vy_istek_gecerli_i,
    output logic                       vy_istek_hazir_o,
    input  logic                       vy_istek_yaz_i,
    input  logic [L1_BLOK_BIT-1:0]     vy_istek_veri_i,
    output logic [L1_BLOK_BIT-1:0]     vy_veri_o,
    output logic                       vy_veri_gecerli_o,
    input  logic                       vy_veri_hazir_i,
    output logic [ADRES_BIT-1:0]       bellek_istek_adres_o,
    output logic                       bellek_istek_gecerli_o,
    input  logic                       bellek_istek_hazir_i,
    output logic                       bellek_istek_yaz_o,
    output logic [BELLEK_VERI_BIT-1:0] bellek_istek_veri_o,
    input  logic [BELLEK_VERI_BIT-1:0] bellek_veri_i,
    input  logic                       bellek_veri_gecerli_i,
    output logic                       bellek_veri_hazir_o,
    output logic [2:0]                 durum_o
);

    localparam int N     = L1_BLOK_BIT / BELLEK_VERI_BIT;
    localparam int K_BIT = $clog2(N);
    localparam int KAYMA = $clog2(BELLEK_VERI_BIT / 8);
    localparam logic [ADRES_BIT-1:0] BLOK_MASKE = ADRES_BIT'(L1_BLOK_BIT / 8 - 1);
    localparam logic [K_BIT-1:0]     SON_K      = K_BIT'(N - 1);

    typedef enum logic [2:0] {
        BOSTA     = 3'd0,
        OKU_ISTEK = 3'd1,
        OKU_BEKLE = 3'd2,
        YAZ_ISTEK = 3'd3,
        YANIT     = 3'd4
    } durum_t;

    durum_t                   durum_q, durum_d;
    logic [K_BIT-1:0]         k_q, k_d;
    logic [ADRES_BIT-1:0]     taban_q, taban_d;
    logic [L1_BLOK_BIT-1:0]   yaz_blok_q, yaz_blok_d;

    // Next values of the registered outputs.
    logic                       vy_istek_hazir_d;
    logic [L1_BLOK_BIT-1:0]     vy_veri_d;
    logic                       vy_veri_gecerli_d;
    logic [ADRES_BIT-1:0]       bellek_istek_adres_d;
    logic                       bellek_istek_gecerli_d;
    logic                       bellek_istek_yaz_d;
    logic [BELLEK_VERI_BIT-1:0] bellek_istek_veri_d;
    logic                       bellek_veri_hazir_d;

    // Handshakes are formed from the registered valid/ready we drive.
    logic istek_hs, bellek_hs, okuma_hs, yanit_hs;
    assign istek_hs  = vy_istek_gecerli_i & vy_istek_hazir_o;
    assign bellek_hs = bellek_istek_gecerli_o & bellek_istek_hazir_i;
    assign okuma_hs  = bellek_veri_gecerli_i & bellek_veri_hazir_o;
    assign yanit_hs  = vy_veri_gecerli_o & vy_veri_hazir_i;

    assign durum_o = durum_q;

    // State register and all output/datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q                <= BOSTA;
            k_q                    <= '0;
            taban_q                <= '0;
            yaz_blok_q             <= '0;
            vy_istek_hazir_o       <= 1'b0;
            vy_veri_o              <= '0;
            vy_veri_gecerli_o      <= 1'b0;
            bellek_istek_adres_o   <= '0;
            bellek_istek_gecerli_o <= 1'b0;
            bellek_istek_yaz_o     <= 1'b0;
            bellek_istek_veri_o    <= '0;
            bellek_veri_hazir_o    <= 1'b0;
        end else begin
            durum_q                <= durum_d;
            k_q                    <= k_d;
            taban_q                <= taban_d;
            yaz_blok_q             <= yaz_blok_d;
            vy_istek_hazir_o       <= vy_istek_hazir_d;
            vy_veri_o              <= vy_veri_d;
            vy_veri_gecerli_o      <= vy_veri_gecerli_d;
            bellek_istek_adres_o   <= bellek_istek_adres_d;
            bellek_istek_gecerli_o <= bellek_istek_gecerli_d;
            bellek_istek_yaz_o     <= bellek_istek_yaz_d;
            bellek_istek_veri_o    <= bellek_istek_veri_d;
            bellek_veri_hazir_o    <= bellek_veri_hazir_d;
        end
    end

    // Next state, beat counter and latched request.
    always_comb begin
        durum_d    = durum_q;
        k_d        = k_q;
        taban_d    = taban_q;
        yaz_blok_d = yaz_blok_q;
        unique case (durum_q)
            BOSTA: begin
                if (istek_hs) begin
                    taban_d    = vy_istek_adres_i & ~BLOK_MASKE;
                    yaz_blok_d = vy_istek_veri_i;
                    k_d        = '0;
                    durum_d    = vy_istek_yaz_i ? YAZ_ISTEK : OKU_ISTEK;
                end
            end
            OKU_ISTEK: begin
                if (bellek_hs) durum_d = OKU_BEKLE;
            end
            OKU_BEKLE: begin
                if (okuma_hs) begin
                    // Counter wraps to 0 after the last beat, so it is clean
                    // for the next request.
                    k_d     = k_q + K_BIT'(1);
                    durum_d = (k_q == SON_K) ? YANIT : OKU_ISTEK;
                end
            end
            YAZ_ISTEK: begin
                if (bellek_hs) begin
                    k_d = k_q + K_BIT'(1);
                    if (k_q == SON_K) durum_d = BOSTA;
                end
            end
            YANIT: begin
                if (yanit_hs) durum_d = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
    end

    // Outputs are decoded from the next state so that they leave the flops
    // in step with the state register.
    always_comb begin
        vy_istek_hazir_d       = (durum_d == BOSTA);
        vy_veri_gecerli_d      = (durum_d == YANIT);
        bellek_istek_gecerli_d = (durum_d == OKU_ISTEK) || (durum_d == YAZ_ISTEK);
        bellek_istek_yaz_d     = (durum_d == YAZ_ISTEK);
        bellek_veri_hazir_d    = (durum_d == OKU_BEKLE);
        bellek_istek_adres_d   = taban_d + (ADRES_BIT'(k_d) << KAYMA);
        bellek_istek_veri_d    = '0;
        if (bellek_istek_yaz_d)
            bellek_istek_veri_d = yaz_blok_d[k_d*BELLEK_VERI_BIT +: BELLEK_VERI_BIT];
        // The read block is built in place. Beat k lands in bits [k*W +: W],
        // and the assembled block stays untouched while it waits in YANIT.
        vy_veri_d = vy_veri_o;
        if (okuma_hs)
            vy_veri_d[k_q*BELLEK_VERI_BIT +: BELLEK_VERI_BIT] = bellek_veri_i;
    end

endmodule

// File: tb/tb_veri_yolu_yanitlayici.sv
// -----------------------------------------------------------------------------
// tb_veri_yolu_yanitlayici
// Directed bench for veri_yolu_yanitlayici. A small memory model answers each
// beat read one cycle after accepting it. The scoreboard predicts the beat
// sequence and the read blocks from the block-level rules:
//   - The base is the address with the low 4 bits cleared.
//   - There are four word beats, sent LSB word first.
//   - Each read block is the four memory words concatenated.
// Literal checks pin latencies and a few known blocks.
// -----------------------------------------------------------------------------
module tb_veri_yolu_yanitlayici;

    localparam int AB = 32;
    localparam int BB = 128;
    localparam int VB = 32;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AB-1:0] vy_istek_adres_i   = '0;
    logic          vy_istek_gecerli_i = 1'b0;
    logic          vy_istek_hazir_o;
    logic          vy_istek_yaz_i     = 1'b0;
    logic [BB-1:0] vy_istek_veri_i    = '0;
    logic [BB-1:0] vy_veri_o;
    logic          vy_veri_gecerli_o;
    logic          vy_veri_hazir_i    = 1'b1;
    logic [AB-1:0] bellek_istek_adres_o;
    logic          bellek_istek_gecerli_o;
    logic          bellek_istek_hazir_i = 1'b1;
    logic          bellek_istek_yaz_o;
    logic [VB-1:0] bellek_istek_veri_o;
    logic [VB-1:0] bellek_veri_i         = '0;
    logic          bellek_veri_gecerli_i = 1'b0;
    logic          bellek_veri_hazir_o;
    logic [2:0]    durum_o;

    veri_yolu_yanitlayici #(.ADRES_BIT(AB), .L1_BLOK_BIT(BB), .BELLEK_VERI_BIT(VB)) dut (
        .clk_i                  (clk),
        .rstn_i                 (rstn_i),
        .vy_istek_adres_i       (vy_istek_adres_i),
        .vy_istek_gecerli_i     (vy_istek_gecerli_i),
        .vy_istek_hazir_o       (vy_istek_hazir_o),
        .vy_istek_yaz_i         (vy_istek_yaz_i),
        .vy_istek_veri_i        (vy_istek_veri_i),
        .vy_veri_o              (vy_veri_o),
        .vy_veri_gecerli_o      (vy_veri_gecerli_o),
        .vy_veri_hazir_i        (vy_veri_hazir_i),
        .bellek_istek_adres_o   (bellek_istek_adres_o),
        .bellek_istek_gecerli_o (bellek_istek_gecerli_o),
        .bellek_istek_hazir_i   (bellek_istek_hazir_i),
        .bellek_istek_yaz_o     (bellek_istek_yaz_o),
        .bellek_istek_veri_o    (bellek_istek_veri_o),
        .bellek_veri_i          (bellek_veri_i),
        .bellek_veri_gecerli_i  (bellek_veri_gecerli_i),
        .bellek_veri_hazir_o    (bellek_veri_hazir_o),
        .durum_o                (durum_o)
    );

    // ---------------- bookkeeping ----------------
    int n_test = 0;
    int n_fail = 0;

    task automatic kontrol(input string ad, input logic [BB-1:0] gercek, input logic [BB-1:0] beklenen);
        n_test++;
        if (gercek !== beklenen) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", ad, gercek, beklenen, cyc);
        end
    endtask

    // ---------------- memory content ----------------
    function automatic logic [VB-1:0] mem_data(input logic [AB-1:0] a);
        if (a[31:4] == 28'h0000103) return 32'hA0 + {30'd0, a[3:2]};
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [BB-1:0] blok_oku(input logic [AB-1:0] taban);
        logic [BB-1:0] b;
        for (int i = 0; i < BB / VB; i++) b[i*VB +: VB] = mem_data(taban + AB'(4 * i));
        return b;
    endfunction

    // ---------------- memory model ----------------
    logic          rd_hs_now   = 1'b0;
    logic          req_hs_now  = 1'b0;
    logic [AB-1:0] req_adr_now = '0;
    logic          rst_pend    = 1'b0;
    logic [AB-1:0] stall_adres = '1;
    int            stall_sayac = 0;

    always @(negedge clk) begin
        rd_hs_now   = bellek_veri_gecerli_i && bellek_veri_hazir_o;
        req_hs_now  = bellek_istek_gecerli_o && bellek_istek_hazir_i && !bellek_istek_yaz_o;
        req_adr_now = bellek_istek_adres_o;
    end

    always @(posedge clk) begin
        #1;
        // A response pending when reset hits stays on the bus until reset ends.
        if (!rstn_i) rst_pend = 1'b1;
        else if (rst_pend) begin
            bellek_veri_gecerli_i = 1'b0;
            rst_pend = 1'b0;
        end else begin
            if (rd_hs_now) bellek_veri_gecerli_i = 1'b0;
            if (req_hs_now) begin
                bellek_veri_gecerli_i = 1'b1;
                bellek_veri_i = mem_data(req_adr_now);
            end
        end
        if (bellek_istek_gecerli_o && bellek_istek_adres_o == stall_adres && stall_sayac < 3) begin
            bellek_istek_hazir_i = 1'b0;
            stall_sayac++;
        end else begin
            bellek_istek_hazir_i = 1'b1;
            if (!(bellek_istek_gecerli_o && bellek_istek_adres_o == stall_adres)) stall_sayac = 0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [AB-1:0] exp_adr_q[$];
    logic          exp_yaz_q[$];
    logic [VB-1:0] exp_dat_q[$];
    logic [BB-1:0] exp_q[$];

    logic          prev_bv  = 1'b0;
    logic [AB-1:0] prev_adr = '0;
    logic          prev_vv  = 1'b0;
    logic [BB-1:0] prev_vy  = '0;
    int            son_yanit_kenar = 0;

    always @(negedge clk) begin
        if (!rstn_i) begin
            exp_adr_q.delete(); exp_yaz_q.delete(); exp_dat_q.delete(); exp_q.delete();
            prev_bv = 1'b0;
            prev_vv = 1'b0;
        end else begin
            if (prev_bv) begin
                kontrol("beat_hold_adr", bellek_istek_adres_o, prev_adr);
                kontrol("beat_hold_vld", bellek_istek_gecerli_o, 1);
            end
            if (prev_vv) begin
                kontrol("blk_hold_data", vy_veri_o, prev_vy);
                kontrol("blk_hold_vld", vy_veri_gecerli_o, 1);
            end
            if (vy_istek_gecerli_i && vy_istek_hazir_o) begin
                logic [AB-1:0] taban;
                taban = vy_istek_adres_i & ~32'hF;
                for (int i = 0; i < BB / VB; i++) begin
                    exp_adr_q.push_back(taban + AB'(4 * i));
                    exp_yaz_q.push_back(vy_istek_yaz_i);
                    exp_dat_q.push_back(vy_istek_veri_i[i*VB +: VB]);
                end
                if (!vy_istek_yaz_i) exp_q.push_back(blok_oku(taban));
            end
            if (bellek_istek_gecerli_o && bellek_istek_hazir_i) begin
                kontrol("beat_expected", exp_adr_q.size() != 0, 1);
                if (exp_adr_q.size() != 0) begin
                    logic [AB-1:0] ea;
                    logic          ey;
                    logic [VB-1:0] ed;
                    ea = exp_adr_q.pop_front();
                    ey = exp_yaz_q.pop_front();
                    ed = exp_dat_q.pop_front();
                    kontrol("beat_adr", bellek_istek_adres_o, ea);
                    kontrol("beat_yaz", bellek_istek_yaz_o, ey);
                    if (ey) kontrol("beat_data", bellek_istek_veri_o, ed);
                end
            end
            if (vy_veri_gecerli_o && vy_veri_hazir_i) begin
                kontrol("blk_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) kontrol("blk_data", vy_veri_o, exp_q.pop_front());
                son_yanit_kenar = cyc + 1;
            end
            prev_bv  = bellek_istek_gecerli_o && !bellek_istek_hazir_i;
            prev_adr = bellek_istek_adres_o;
            prev_vv  = vy_veri_gecerli_o && !vy_veri_hazir_i;
            prev_vy  = vy_veri_o;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge
    // with t = index of that edge.
    task automatic istek_gonder(input logic [AB-1:0] a, input logic yaz, input logic [BB-1:0] blk, output int t);
        vy_istek_adres_i   = a;
        vy_istek_yaz_i     = yaz;
        vy_istek_veri_i    = blk;
        vy_istek_gecerli_i = 1'b1;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vy_istek_hazir_o) begin
                @(posedge clk);
                #1;
                t = cyc;
                break;
            end
        end
        vy_istek_gecerli_i = 1'b0;
        if (t < 0) kontrol("istek_timeout", 0, 1);
    endtask

    task automatic gecerli_bekle(output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vy_veri_gecerli_o) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) kontrol("gecerli_timeout", 0, 1);
    endtask

    task automatic bosta_bekle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (vy_istek_hazir_o && exp_adr_q.size() == 0 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) kontrol("bosta_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic cikislar_sifir(input string ad);
        kontrol({ad, "_ctrl"}, {vy_istek_hazir_o, vy_veri_gecerli_o, bellek_istek_gecerli_o,
                                bellek_istek_yaz_o, bellek_veri_hazir_o, durum_o}, 0);
        kontrol({ad, "_blk"}, vy_veri_o, 0);
        kontrol({ad, "_bellek"}, {bellek_istek_adres_o, bellek_istek_veri_o}, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t, t2, c, sayac;
        logic gorundu;
        logic [BB-1:0] tut;

        repeat (3) @(posedge clk);
        #1;
        cikislar_sifir("reset");
        @(negedge clk);
        #2 rstn_i = 1'b1;
        @(posedge clk);
        #1;
        kontrol("hazir_after_reset", vy_istek_hazir_o, 1);

        // Read of 0x1034: base 0x1030, block valid from cycle T+9.
        istek_gonder(32'h0000_1034, 1'b0, '0, t);
        kontrol("rd_beat0_adr", bellek_istek_adres_o, 32'h0000_1030);
        kontrol("rd_beat0_vld", {bellek_istek_gecerli_o, bellek_istek_yaz_o}, 2'b10);
        gecerli_bekle(c);
        kontrol("rd_latency", c - t, 8);
        kontrol("rd_block_lit", vy_veri_o, 128'h000000A3_000000A2_000000A1_000000A0);
        bosta_bekle();

        // Write of 0x2000: four write beats, no read response, ready at T+5.
        istek_gonder(32'h0000_2000, 1'b1, 128'h44444444_33333333_22222222_11111111, t);
        kontrol("wr_beat0", {bellek_istek_yaz_o, bellek_istek_adres_o, bellek_istek_veri_o},
                {1'b1, 32'h0000_2000, 32'h1111_1111});
        gorundu = 1'b0;
        c = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (vy_veri_gecerli_o) gorundu = 1'b1;
            if (vy_istek_hazir_o) begin
                c = cyc;
                break;
            end
        end
        kontrol("wr_done_latency", c - t, 4);
        kontrol("wr_no_resp", gorundu, 0);
        bosta_bekle();

        // L1 not ready for 5 cycles in YANIT: block stable, no new request taken.
        vy_veri_hazir_i = 1'b0;
        istek_gonder(32'h0000_1000, 1'b0, '0, t);
        gecerli_bekle(c);
        tut = vy_veri_o;
        kontrol("yanit_blk_lit", tut, 128'h4A56100C_4A521008_4A5E1004_4A5A1000);
        repeat (5) begin
            @(negedge clk);
            kontrol("yanit_stable", vy_veri_o, tut);
            kontrol("yanit_istek_hazir", vy_istek_hazir_o, 0);
        end
        @(posedge clk);
        #1 vy_veri_hazir_i = 1'b1;
        bosta_bekle();

        // Memory stalls beat 2 (0x1038) for 3 cycles.
        stall_adres = 32'h0000_1038;
        istek_gonder(32'h0000_1030, 1'b0, '0, t);
        sayac = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bellek_istek_gecerli_o && bellek_istek_adres_o == 32'h0000_1038) sayac++;
            if (vy_veri_gecerli_o) break;
        end
        kontrol("stall_cycles", sayac, 4);
        kontrol("stall_block_lit", vy_veri_o, 128'h000000A3_000000A2_000000A1_000000A0);
        stall_adres = '1;
        bosta_bekle();

        // Reset while the beat-2 response is pending.
        istek_gonder(32'h0000_1030, 1'b0, '0, t);
        gorundu = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bellek_veri_gecerli_i && bellek_veri_hazir_o && bellek_istek_adres_o == 32'h0000_1038) begin
                gorundu = 1'b1;
                break;
            end
        end
        kontrol("rst_point_reached", gorundu, 1);
        #2 rstn_i = 1'b0;
        #1 cikislar_sifir("async_rst");
        repeat (3) begin
            @(negedge clk);
            kontrol("rst_stall_hazir", bellek_veri_hazir_o, 0);
        end
        #2 rstn_i = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        istek_gonder(32'h0000_1030, 1'b0, '0, t);
        gecerli_bekle(c);
        kontrol("post_rst_block", vy_veri_o, 128'h000000A3_000000A2_000000A1_000000A0);
        bosta_bekle();

        // Back-to-back reads with request valid held high.
        istek_gonder(32'h0000_1000, 1'b0, '0, t);
        istek_gonder(32'h0000_2000, 1'b0, '0, t2);
        kontrol("b2b_gap", t2 - son_yanit_kenar, 1);
        bosta_bekle();

        kontrol("queues_empty", exp_adr_q.size() + exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
